// File: rtl/cpu_regfile_sync_2r1w.sv
// Two-read / one-write register file with registered reads, x0 hard-wired to zero and a sequenced clear.
// Optional same-edge write-to-read forwarding is enabled by defining CPU_REGFILE_BYPASS_EN.
module cpu_regfile_sync_2r1w #(
  parameter int p_width        = 32,
  parameter int p_half_regfile = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  output logic               o_busy,
  output logic               o_addr_oob,
  input  logic [4:0]         i_rd1_addr,
  input  logic [4:0]         i_rd2_addr,
  output logic [p_width-1:0] o_rd1_data,
  output logic [p_width-1:0] o_rd2_data,
  input  logic               i_wr_en,
  input  logic [4:0]         i_wr_addr,
  input  logic [p_width-1:0] i_wr_data
);

  localparam int         DEPTH = (p_half_regfile != 0) ? 16 : 32;
  localparam int         AW    = (p_half_regfile != 0) ? 4 : 5;
  localparam logic [4:0] LAST  = 5'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [p_width-1:0] rd1_q, rd1_d;
  logic [p_width-1:0] rd2_q, rd2_d;

  // Storage deliberately carries no reset so it can map onto distributed RAM.
  logic [p_width-1:0] mem [DEPTH];

  logic               wr_oob, rd1_oob, rd2_oob;
  logic               wr_ok;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [p_width-1:0] mem_wdata;

  if (p_half_regfile != 0) begin : g_half
    assign wr_oob  = i_wr_addr[4];
    assign rd1_oob = i_rd1_addr[4];
    assign rd2_oob = i_rd2_addr[4];
  end else begin : g_full
    assign wr_oob  = 1'b0;
    assign rd1_oob = 1'b0;
    assign rd2_oob = 1'b0;
  end

  assign o_addr_oob = (i_wr_en & wr_oob) | rd1_oob | rd2_oob;
  assign wr_ok      = (state_q == IDLE) && i_wr_en && (i_wr_addr != 5'd0) && !wr_oob;
  assign o_busy     = (state_q == CLEAR);
  assign o_rd1_data = rd1_q;
  assign o_rd2_data = rd2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = wr_ok;
    mem_waddr = i_wr_addr[AW-1:0];
    mem_wdata = i_wr_data;
    case (state_q)
      IDLE: begin
        if (i_clear) begin
          state_d = CLEAR;
          cnt_d   = 5'd1;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[AW-1:0];
        mem_wdata = '0;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = 5'd1;
      end
    endcase
  end

  // Read ports: zero for x0, out-of-range addresses and anything issued during a clear.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (state_q == IDLE) begin
      if (!rd1_oob && (i_rd1_addr != 5'd0)) begin
        rd1_d = mem[i_rd1_addr[AW-1:0]];
`ifdef CPU_REGFILE_BYPASS_EN
        if (wr_ok && (i_wr_addr == i_rd1_addr)) begin
          rd1_d = i_wr_data;
        end
`endif
      end
      if (!rd2_oob && (i_rd2_addr != 5'd0)) begin
        rd2_d = mem[i_rd2_addr[AW-1:0]];
`ifdef CPU_REGFILE_BYPASS_EN
        if (wr_ok && (i_wr_addr == i_rd2_addr)) begin
          rd2_d = i_wr_data;
        end
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= 5'd1;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_cpu_regfile_sync_2r1w.sv
// Bench for cpu_regfile_sync_2r1w: a 32-entry instance driven from a vector table and
// a scoreboard, plus a 16-entry instance for the out-of-range address behaviour.
module tb_cpu_regfile_sync_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, busy, oob;
  logic [4:0]  rd1_addr, rd2_addr, wr_addr;
  logic [31:0] rd1_data, rd2_data, wr_data;
  logic        wr_en;

  logic        h_clear, h_busy, h_oob;
  logic [4:0]  h_rd1_addr, h_rd2_addr, h_wr_addr;
  logic [31:0] h_rd1_data, h_rd2_data, h_wr_data;
  logic        h_wr_en;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_regfile_sync_2r1w #(.p_width(32), .p_half_regfile(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .o_busy(busy), .o_addr_oob(oob),
    .i_rd1_addr(rd1_addr), .i_rd2_addr(rd2_addr), .o_rd1_data(rd1_data), .o_rd2_data(rd2_data),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );

  cpu_regfile_sync_2r1w #(.p_width(32), .p_half_regfile(1)) dut_h (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(h_clear), .o_busy(h_busy), .o_addr_oob(h_oob),
    .i_rd1_addr(h_rd1_addr), .i_rd2_addr(h_rd2_addr), .o_rd1_data(h_rd1_data), .o_rd2_data(h_rd2_data),
    .i_wr_en(h_wr_en), .i_wr_addr(h_wr_addr), .i_wr_data(h_wr_data)
  );

  typedef struct {
    string       name;
    logic [4:0]  a1, a2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] e1, e2;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] e1, e2;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

`ifdef CPU_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic vec_t mkv(input string n, input logic [4:0] a1, input logic [4:0] a2,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic chk, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.name = n; v.a1 = a1; v.a2 = a2; v.we = we; v.wa = wa; v.wd = wd;
    v.chk = chk; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one vector for a cycle; expected read data is queued and retired after the edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    rd1_addr = v.a1;
    rd2_addr = v.a2;
    wr_en    = v.we;
    wr_addr  = v.wa;
    wr_data  = v.wd;
    if (v.chk) begin
      e.name = v.name; e.e1 = v.e1; e.e2 = v.e2;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (v.chk) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL %s: scoreboard empty, got 0 entries, expected 1", v.name);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, ".rd1"}, rd1_data, e.e1);
        checkOutput({e.name, ".rd2"}, rd2_data, e.e2);
        checkOutput({e.name, ".oob"}, 32'(oob), 32'd0);
      end
    end
  endtask

  // Counts edges until each busy flag drops; -1 if it never does within the budget.
  task automatic waitBusyFall(output int nf, output int nh);
    nf = -1;
    nh = -1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (nf < 0 && !busy)   nf = i;
      if (nh < 0 && !h_busy) nh = i;
      if (nf >= 0 && nh >= 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nf, nh, n;

    rst_n = 1'b1;
    clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd1_addr = '0; rd2_addr = '0;
    h_clear = 1'b0; h_wr_en = 1'b0; h_wr_addr = '0; h_wr_data = '0; h_rd1_addr = '0; h_rd2_addr = '0;

    // Asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_rd1", rd1_data, 32'd0);
    checkOutput("rst_rd2", rd2_data, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_h_busy", 32'(h_busy), 32'd1);
    checkOutput("rst_oob", 32'(oob), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    waitBusyFall(nf, nh);
    checkOutput("rst_busy_len", 32'(nf), 32'd31);
    checkOutput("rst_h_busy_len", 32'(nh), 32'd15);

    for (int i = 1; i <= 31; i++) begin
      applyStimulus(mkv($sformatf("post_rst_x%0d", i), 5'(i), 5'(32 - i), 1'b0, 5'd0, 32'd0,
                        1'b1, 32'd0, 32'd0));
    end

    // Main function table
    vecs.push_back(mkv("wr_x5",      5'd0,  5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mkv("wr_x6",      5'd5,  5'd0,  1'b1, 5'd6,  32'h12345678, 1'b1, 32'hDEADBEEF, 32'd0));
    vecs.push_back(mkv("dual_rd",    5'd5,  5'd6,  1'b0, 5'd0,  32'd0,        1'b1, 32'hDEADBEEF, 32'h12345678));
    vecs.push_back(mkv("wr_x0",      5'd0,  5'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mkv("rd_x0",      5'd0,  5'd6,  1'b0, 5'd0,  32'd0,        1'b1, 32'd0, 32'h12345678));
    vecs.push_back(mkv("rd_swap",    5'd6,  5'd5,  1'b0, 5'd0,  32'd0,        1'b1, 32'h12345678, 32'hDEADBEEF));
    vecs.push_back(mkv("wr_x7",      5'd0,  5'd0,  1'b1, 5'd7,  32'h00001111, 1'b1, 32'd0, 32'd0));
    vecs.push_back(mkv("bypass_x7",  5'd7,  5'd7,  1'b1, 5'd7,  32'h00002222, 1'b1,
                       BYP ? 32'h00002222 : 32'h00001111, BYP ? 32'h00002222 : 32'h00001111));
    vecs.push_back(mkv("rd_x7",      5'd7,  5'd5,  1'b0, 5'd0,  32'd0,        1'b1, 32'h00002222, 32'hDEADBEEF));
    vecs.push_back(mkv("wr_x31",     5'd31, 5'd1,  1'b1, 5'd31, 32'hA5A55A5A, 1'b1,
                       BYP ? 32'hA5A55A5A : 32'd0, 32'd0));
    vecs.push_back(mkv("rd_x31",     5'd31, 5'd31, 1'b0, 5'd0,  32'd0,        1'b1, 32'hA5A55A5A, 32'hA5A55A5A));
    vecs.push_back(mkv("wr_x1",      5'd31, 5'd1,  1'b1, 5'd1,  32'h00000001, 1'b1,
                       32'hA5A55A5A, BYP ? 32'h00000001 : 32'd0));
    vecs.push_back(mkv("rd_x1",      5'd1,  5'd7,  1'b0, 5'd0,  32'd0,        1'b1, 32'h00000001, 32'h00002222));
    vecs.push_back(mkv("wr_disabled",5'd5,  5'd0,  1'b0, 5'd5,  32'd0,        1'b1, 32'hDEADBEEF, 32'd0));
    vecs.push_back(mkv("rd_after_dis",5'd5, 5'd6,  1'b0, 5'd0,  32'd0,        1'b1, 32'hDEADBEEF, 32'h12345678));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset mid-operation: outputs hold data, reset must zero them without a clock edge
    applyStimulus(mkv("pre_rst_rd", 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 32'hDEADBEEF, 32'h12345678));
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midop_rst_rd1", rd1_data, 32'd0);
    checkOutput("midop_rst_rd2", rd2_data, 32'd0);
    checkOutput("midop_rst_busy", 32'(busy), 32'd1);
    checkOutput("midop_rst_h_busy", 32'(h_busy), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    waitBusyFall(nf, nh);
    checkOutput("midop_busy_len", 32'(nf), 32'd31);
    checkOutput("midop_h_busy_len", 32'(nh), 32'd15);
    applyStimulus(mkv("midop_rd_x5", 5'd5, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 32'd0));

    // Clear sequence with ignored write/clear and reads during busy
    applyStimulus(mkv("wr_x3",  5'd0, 5'd0,  1'b1, 5'd3,  32'h000000AA, 1'b0, 32'd0, 32'd0));
    applyStimulus(mkv("wr_x20", 5'd0, 5'd0,  1'b1, 5'd20, 32'h00002020, 1'b0, 32'd0, 32'd0));
    applyStimulus(mkv("rd_x3",  5'd3, 5'd20, 1'b0, 5'd0,  32'd0, 1'b1, 32'h000000AA, 32'h00002020));
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checkOutput("clr_busy_start", 32'(busy), 32'd1);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b0;
      clear = 1'b0;
      if (i == 6) begin
        checkOutput("clr_rd1_during_busy", rd1_data, 32'd0);
        checkOutput("clr_rd2_during_busy", rd2_data, 32'd0);
      end
      if (!busy) begin
        n = i;
        break;
      end
      if (i == 5) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000055;
        rd1_addr = 5'd3; rd2_addr = 5'd20; clear = 1'b1;
      end
    end
    checkOutput("clr_busy_len", 32'(n), 32'd31);
    applyStimulus(mkv("post_clr_rd", 5'd3, 5'd20, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 32'd0));

    // Half-size instance: out-of-range accesses
    h_wr_en = 1'b1; h_wr_addr = 5'd1;  h_wr_data = 32'h0000CAFE;
    @(posedge clk); #1;
    h_wr_addr = 5'd4;  h_wr_data = 32'h00004444;
    @(posedge clk); #1;
    h_wr_addr = 5'd15; h_wr_data = 32'h00000F0F;
    @(posedge clk); #1;
    h_wr_addr = 5'd17; h_wr_data = 32'hBAD0BAD0;
    #1;
    checkOutput("half_wr_oob", 32'(h_oob), 32'd1);
    @(posedge clk); #1;
    h_wr_en = 1'b0;
    h_rd1_addr = 5'd1; h_rd2_addr = 5'd15;
    #1;
    checkOutput("half_wr_dis_no_oob", 32'(h_oob), 32'd0);
    @(posedge clk); #1;
    checkOutput("half_rd_x1", h_rd1_data, 32'h0000CAFE);
    checkOutput("half_rd_x15", h_rd2_data, 32'h00000F0F);
    h_rd1_addr = 5'd20; h_rd2_addr = 5'd4;
    rd1_addr = 5'd20; rd2_addr = 5'd31;
    #1;
    checkOutput("half_rd_oob", 32'(h_oob), 32'd1);
    checkOutput("full_rd20_no_oob", 32'(oob), 32'd0);
    @(posedge clk); #1;
    checkOutput("half_rd_oob_data", h_rd1_data, 32'd0);
    checkOutput("half_rd_x4", h_rd2_data, 32'h00004444);

    // Reset in the middle of a clear restarts the full sequence
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("midclr_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midclr_rst_rd1", rd1_data, 32'd0);
    checkOutput("midclr_rst_rd2", rd2_data, 32'd0);
    checkOutput("midclr_rst_h_rd2", h_rd2_data, 32'd0);
    checkOutput("midclr_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    waitBusyFall(nf, nh);
    checkOutput("midclr_busy_len", 32'(nf), 32'd31);
    checkOutput("midclr_h_busy_len", 32'(nh), 32'd15);
    h_rd1_addr = 5'd1; h_rd2_addr = 5'd15;
    applyStimulus(mkv("final_rd", 5'd3, 5'd31, 1'b0, 5'd0, 32'd0, 1'b1, 32'd0, 32'd0));
    checkOutput("final_h_rd_x1", h_rd1_data, 32'd0);
    checkOutput("final_h_rd_x15", h_rd2_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
